// File: rtl/gb_cart_pkg.sv
// Shared types and constants for the cartridge memory bank controller model.
package gb_cart_pkg;

    typedef enum logic [1:0] {
        MBC_NONE = 2'd0,
        MBC_1    = 2'd1,
        MBC_5    = 2'd2
    } mbc_type_e;

    localparam logic [15:0] ROM0_HI    = 16'h3FFF;
    localparam logic [15:0] ROMX_HI    = 16'h7FFF;
    localparam logic [15:0] CRAM_LO    = 16'hA000;
    localparam logic [15:0] CRAM_HI    = 16'hBFFF;
    localparam logic [3:0]  RAM_EN_KEY = 4'hA;

    function automatic mbc_type_e to_mbc_type(input int t);
        case (t)
            1:       return MBC_1;
            2:       return MBC_5;
            default: return MBC_NONE;
        endcase
    endfunction

    function automatic logic [31:0] low_mask(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/cart_bus_edge.sv
// Turns a (possibly multi-cycle) cart write strobe into a single commit pulse
// and holds the address/data of the most recent commit.
module cart_bus_edge (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        cart_write_i,
    input  logic        cart_wdata_send_i,
    input  logic [15:0] cart_addr_i,
    input  logic [7:0]  cart_wdata_i,
    output logic        commit_o,
    output logic [15:0] cmt_addr_o,
    output logic [7:0]  cmt_data_o
);
    logic        wr_prev_q;
    logic [15:0] addr_q;
    logic [7:0]  data_q;

    assign commit_o   = cart_write_i & cart_wdata_send_i & ~wr_prev_q;
    // Bus values pass straight through on the commit cycle so the effect lands one clk later.
    assign cmt_addr_o = commit_o ? cart_addr_i  : addr_q;
    assign cmt_data_o = commit_o ? cart_wdata_i : data_q;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            // Held high so a strobe already active at reset release never commits.
            wr_prev_q <= 1'b1;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            wr_prev_q <= cart_write_i;
            if (commit_o) begin
                addr_q <= cart_addr_i;
                data_q <= cart_wdata_i;
            end
        end
    end

endmodule

// File: rtl/cart_mbc_mapper.sv
// Cartridge MBC model: bank/enable registers plus registered ROM/RAM address
// generation for ROM-only, MBC1 and MBC5 cartridges.
module cart_mbc_mapper
    import gb_cart_pkg::*;
#(
    parameter int MBC_TYPE       = 0,
    parameter int ROM_BANKS_LOG2 = 7,
    parameter int RAM_BANKS_LOG2 = 2,
    parameter int RAM_PRESENT    = 1
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        n_cart_clk,
    input  logic        cart_cs,
    input  logic        cart_write,
    input  logic [15:0] cart_addr,
    input  logic [7:0]  cart_wdata,
    input  logic        cart_wdata_send,
    output logic [22:0] rom_addr,
    output logic        rom_oe,
    output logic [16:0] ram_addr,
    output logic        ram_oe,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    output logic        ram_enabled
);
    localparam mbc_type_e   MBC      = to_mbc_type(MBC_TYPE);
    localparam int          ROM_W    = (14 + ROM_BANKS_LOG2 > 23) ? 23 : 14 + ROM_BANKS_LOG2;
    localparam int          RAM_W    = (13 + RAM_BANKS_LOG2 > 17) ? 17 : 13 + RAM_BANKS_LOG2;
    localparam logic [22:0] ROM_MASK = 23'(low_mask(ROM_W));
    localparam logic [16:0] RAM_MASK = 17'(low_mask(RAM_W));

    logic        commit;
    logic [15:0] cmt_addr;
    logic [7:0]  cmt_data;

    logic        ram_en_q, mode_q;
    logic [4:0]  bank1_q;
    logic [1:0]  bank2_q;
    logic [8:0]  rom_bank_q;
    logic [3:0]  ram_bank_q;

    logic [22:0] rom_addr_q, rom_map;
    logic [16:0] ram_addr_q, ram_map;
    logic        rom_oe_q, ram_oe_q, ram_we_q;
    logic [7:0]  ram_wdata_q;
    logic        in_rom0, in_cram, ram_en_eff, ram_ok, reg_wr;
    logic [1:0]  mbc1_hi;

    logic unused_ok;
    assign unused_ok = &{1'b0, n_cart_clk};

    cart_bus_edge u_edge (
        .clk               (clk),
        .n_reset           (n_reset),
        .cart_write_i      (cart_write),
        .cart_wdata_send_i (cart_wdata_send),
        .cart_addr_i       (cart_addr),
        .cart_wdata_i      (cart_wdata),
        .commit_o          (commit),
        .cmt_addr_o        (cmt_addr),
        .cmt_data_o        (cmt_data)
    );

    always_comb begin
        in_rom0    = cart_addr <= ROM0_HI;
        in_cram    = cart_cs && (cart_addr >= CRAM_LO) && (cart_addr <= CRAM_HI);
        mbc1_hi    = mode_q ? bank2_q : 2'b00;
        rom_map    = '0;
        ram_map    = '0;
        ram_en_eff = ram_en_q;
        case (MBC)
            MBC_1: begin
                rom_map = in_rom0 ? 23'({mbc1_hi, 5'b0, cart_addr[13:0]})
                                  : 23'({bank2_q, bank1_q, cart_addr[13:0]});
                ram_map = 17'({mbc1_hi, cart_addr[12:0]});
            end
            MBC_5: begin
                rom_map = in_rom0 ? 23'(cart_addr[13:0]) : {rom_bank_q, cart_addr[13:0]};
                ram_map = {ram_bank_q, cart_addr[12:0]};
            end
            default: begin
                rom_map    = 23'(cart_addr[14:0]);
                ram_map    = 17'(cart_addr[12:0]);
                ram_en_eff = 1'b1;
            end
        endcase
        ram_ok = in_cram && ram_en_eff && (RAM_PRESENT != 0);
        reg_wr = commit && !cart_cs && (cmt_addr <= ROMX_HI);
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            ram_en_q    <= 1'b0;
            bank1_q     <= 5'h01;
            bank2_q     <= '0;
            mode_q      <= 1'b0;
            rom_bank_q  <= 9'h001;
            ram_bank_q  <= '0;
            rom_addr_q  <= '0;
            rom_oe_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_oe_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
        end else begin
            rom_addr_q <= rom_map & ROM_MASK;
            rom_oe_q   <= cart_addr <= ROMX_HI;
            ram_addr_q <= ram_map & RAM_MASK;
            ram_oe_q   <= ram_ok;
            ram_we_q   <= commit && ram_ok;
            if (commit && ram_ok)
                ram_wdata_q <= cmt_data;
            if (reg_wr) begin
                case (MBC)
                    MBC_1: begin
                        case (cmt_addr[14:13])
                            2'd0:    ram_en_q <= (cmt_data[3:0] == RAM_EN_KEY);
                            2'd1:    bank1_q  <= (cmt_data[4:0] == 5'd0) ? 5'd1 : cmt_data[4:0];
                            2'd2:    bank2_q  <= cmt_data[1:0];
                            default: mode_q   <= cmt_data[0];
                        endcase
                    end
                    MBC_5: begin
                        case (cmt_addr[14:13])
                            2'd0: ram_en_q <= (cmt_data[3:0] == RAM_EN_KEY);
                            2'd1: begin
                                if (cmt_addr[12]) rom_bank_q[8]   <= cmt_data[0];
                                else              rom_bank_q[7:0] <= cmt_data;
                            end
                            2'd2:    ram_bank_q <= cmt_data[3:0];
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rom_addr    = rom_addr_q;
    assign rom_oe      = rom_oe_q;
    assign ram_addr    = ram_addr_q;
    assign ram_oe      = ram_oe_q;
    assign ram_we      = ram_we_q;
    assign ram_wdata   = ram_wdata_q;
    assign ram_enabled = ram_en_q;

endmodule

// File: tb/tb_cart_mbc_mapper.sv
// Bench for cart_mbc_mapper: four configurations (MBC1, MBC5 9-bit ROM, MBC5 7-bit ROM,
// ROM-only) share one bus; vector table, hand sequences and random traffic vs a model.
module tb_cart_mbc_mapper;
    localparam int NDUT = 4;
    localparam logic [NDUT-1:0][3:0] MT = {4'd0, 4'd2, 4'd2, 4'd1};
    localparam logic [NDUT-1:0][3:0] RL = {4'd7, 4'd7, 4'd9, 4'd7};
    localparam int RAML = 2;

    logic clk, n_reset, n_cart_clk, cart_cs, cart_write, cart_wdata_send;
    logic [15:0] cart_addr;
    logic [7:0]  cart_wdata;
    logic [NDUT-1:0][22:0] rom_addr_w;
    logic [NDUT-1:0][16:0] ram_addr_w;
    logic [NDUT-1:0][7:0]  ram_wdata_w;
    logic [NDUT-1:0]       rom_oe_w, ram_oe_w, ram_we_w, ram_en_w;

    assign n_cart_clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        cart_mbc_mapper #(
            .MBC_TYPE       (int'(MT[g])),
            .ROM_BANKS_LOG2 (int'(RL[g])),
            .RAM_BANKS_LOG2 (RAML),
            .RAM_PRESENT    (1)
        ) u_dut (
            .clk             (clk),
            .n_reset         (n_reset),
            .n_cart_clk      (n_cart_clk),
            .cart_cs         (cart_cs),
            .cart_write      (cart_write),
            .cart_addr       (cart_addr),
            .cart_wdata      (cart_wdata),
            .cart_wdata_send (cart_wdata_send),
            .rom_addr        (rom_addr_w[g]),
            .rom_oe          (rom_oe_w[g]),
            .ram_addr        (ram_addr_w[g]),
            .ram_oe          (ram_oe_w[g]),
            .ram_we          (ram_we_w[g]),
            .ram_wdata       (ram_wdata_w[g]),
            .ram_enabled     (ram_en_w[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h", name, g, act, exp);
        end
    endtask

    // Behavioural model: banks as integers, addresses as bank*size + offset.
    typedef struct {
        bit en; int b1, b2, mode, rb, xb; bit wp;
        int rom_a, ram_a, wd; bit rom_oe, ram_oe, ram_we;
    } mst_t;
    mst_t ms [NDUT];

    function automatic mst_t mstep(input int g, input mst_t s, input bit rstn, input bit cs,
                                   input bit wr, input bit snd, input int a, input int d);
        mst_t n;
        int mt, romw, ramw, rbank, xbank;
        bit commit, ramok;
        mt   = int'(MT[g]);
        romw = (14 + int'(RL[g]) > 23) ? 23 : 14 + int'(RL[g]);
        ramw = (13 + RAML > 17) ? 17 : 13 + RAML;
        n = s;
        if (!rstn) begin
            n = '{default: 0};
            n.b1 = 1; n.rb = 1; n.wp = 1;
            return n;
        end
        commit = wr && snd && !s.wp;
        n.wp   = wr;
        ramok  = cs && a >= 'hA000 && a < 'hC000 && (mt == 0 || s.en);
        if (mt == 0) n.rom_a = a % 32768;
        else begin
            if (a < 'h4000) rbank = (mt == 1 && s.mode != 0) ? s.b2 * 32 : 0;
            else            rbank = (mt == 1) ? s.b2 * 32 + s.b1 : s.rb;
            n.rom_a = (rbank * 16384 + a % 16384) % (1 << romw);
        end
        xbank   = (mt == 1) ? ((s.mode != 0) ? s.b2 : 0) : (mt == 2) ? s.xb : 0;
        n.ram_a = (xbank * 8192 + a % 8192) % (1 << ramw);
        n.rom_oe = a < 'h8000;
        n.ram_oe = ramok;
        n.ram_we = commit && ramok;
        if (n.ram_we) n.wd = d;
        if (commit && !cs && a < 'h8000) begin
            if (mt == 1) begin
                case (a / 8192)
                    0: n.en   = (d % 16) == 10;
                    1: n.b1   = (d % 32 == 0) ? 1 : d % 32;
                    2: n.b2   = d % 4;
                    default: n.mode = d % 2;
                endcase
            end else if (mt == 2) begin
                if (a < 'h2000)      n.en = (d % 16) == 10;
                else if (a < 'h3000) n.rb = (s.rb / 256) * 256 + d;
                else if (a < 'h4000) n.rb = (d % 2) * 256 + s.rb % 256;
                else if (a < 'h6000) n.xb = d % 16;
            end
        end
        return n;
    endfunction

    task automatic check_model();
        for (int g = 0; g < NDUT; g++) begin
            chk("m_rom_oe", g, 32'(rom_oe_w[g]), 32'(ms[g].rom_oe));
            chk("m_ram_oe", g, 32'(ram_oe_w[g]), 32'(ms[g].ram_oe));
            chk("m_ram_we", g, 32'(ram_we_w[g]), 32'(ms[g].ram_we));
            chk("m_ram_enabled", g, 32'(ram_en_w[g]), 32'(ms[g].en));
            if (ms[g].rom_oe) chk("m_rom_addr", g, 32'(rom_addr_w[g]), ms[g].rom_a);
            if (ms[g].ram_oe) chk("m_ram_addr", g, 32'(ram_addr_w[g]), ms[g].ram_a);
            if (ms[g].ram_we) chk("m_ram_wdata", g, 32'(ram_wdata_w[g]), ms[g].wd);
        end
    endtask

    // One clk: apply inputs, advance the model, sample 1 time unit after the edge.
    task automatic drive(input bit rstn, input bit cs, input bit wr, input bit snd,
                         input logic [15:0] a, input logic [7:0] d);
        n_reset = rstn; cart_cs = cs; cart_write = wr; cart_wdata_send = snd;
        cart_addr = a; cart_wdata = d;
        for (int g = 0; g < NDUT; g++) ms[g] = mstep(g, ms[g], rstn, cs, wr, snd, int'(a), int'(d));
        @(posedge clk);
        #1;
        check_model();
    endtask

    localparam int M_ROM = 1, M_ROMOE = 2, M_RAM = 4, M_RAMOE = 8, M_WE = 16, M_WD = 32, M_ALL = 63;
    typedef struct {
        bit rstn, cs, wr, snd; int a, d;
        int dut, mask, erom, eram; bit erom_oe, eram_oe, ewe; int ewd;
    } vec_t;
    vec_t tv [$];

    function automatic vec_t mk(input bit rstn, input bit cs, input bit wr, input bit snd,
                                input int a, input int d, input int dut, input int mask,
                                input int erom, input int eram, input bit erom_oe,
                                input bit eram_oe, input bit ewe, input int ewd);
        vec_t v;
        v.rstn = rstn; v.cs = cs; v.wr = wr; v.snd = snd; v.a = a; v.d = d;
        v.dut = dut; v.mask = mask; v.erom = erom; v.eram = eram;
        v.erom_oe = erom_oe; v.eram_oe = eram_oe; v.ewe = ewe; v.ewd = ewd;
        return v;
    endfunction

    function automatic vec_t wrv(input int a, input int d);
        return mk(1, a >= 'h8000, 1, 1, a, d, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic vec_t idle(input int a);
        return mk(1, a >= 'h8000, 0, 0, a, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    logic [15:0] ra;
    logic [7:0]  rd;
    bit          rw, rs, rr;

    initial begin
        n_reset = 1'b0; cart_cs = 1'b0; cart_write = 1'b0; cart_wdata_send = 1'b0;
        cart_addr = '0; cart_wdata = '0;

        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, M_ALL, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, M_ALL, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 0, 0, 0, 'h4000, 0, 0, M_ROM | M_ROMOE, 'h04000, 0, 1, 0, 0, 0));
        tv.push_back(mk(1, 1, 0, 0, 'hA000, 0, 0, M_RAMOE | M_ROMOE, 0, 0, 0, 0, 0, 0));
        tv.push_back(wrv('h2000, 'h00));
        tv.push_back(mk(1, 0, 0, 0, 'h4123, 0, 0, M_ROM, 'h04123, 0, 1, 0, 0, 0));
        tv.push_back(wrv('h2000, 'h1F));
        tv.push_back(mk(1, 0, 0, 0, 'h4123, 0, 0, M_ROM, 'h7C123, 0, 1, 0, 0, 0));
        tv.push_back(wrv('h0000, 'h0A)); tv.push_back(idle('h0000));
        tv.push_back(wrv('h4000, 'h02)); tv.push_back(idle('h0000));
        tv.push_back(wrv('h6000, 'h01)); tv.push_back(idle('h0000));
        tv.push_back(mk(1, 1, 0, 0, 'hA010, 0, 0, M_RAM | M_RAMOE, 0, 'h04010, 0, 1, 0, 0));
        tv.push_back(mk(1, 0, 0, 0, 'h0010, 0, 0, M_ROM | M_ROMOE, 'h100010, 0, 1, 0, 0, 0));
        tv.push_back(wrv('h6000, 'h00)); tv.push_back(idle('h0000));
        tv.push_back(wrv('h2000, 'hFF)); tv.push_back(idle('h0000));
        tv.push_back(wrv('h3000, 'h01)); tv.push_back(idle('h0000));
        tv.push_back(mk(1, 0, 0, 0, 'h7FFF, 0, 1, M_ROM, 'h7FFFFF, 0, 1, 0, 0, 0));
        tv.push_back(mk(1, 0, 0, 0, 'h7FFF, 0, 2, M_ROM, 'h1FFFFF, 0, 1, 0, 0, 0));
        tv.push_back(wrv('h4000, 'h03)); tv.push_back(idle('h0000));
        tv.push_back(mk(1, 1, 0, 0, 'hA123, 0, 1, M_RAM | M_RAMOE, 0, 'h06123, 0, 1, 0, 0));
        tv.push_back(wrv('h2000, 'h00)); tv.push_back(idle('h0000));
        tv.push_back(wrv('h3000, 'h00)); tv.push_back(idle('h0000));
        tv.push_back(mk(1, 0, 0, 0, 'h4001, 0, 1, M_ROM, 'h00001, 0, 1, 0, 0, 0));
        tv.push_back(mk(1, 0, 0, 0, 'h5ABC, 0, 3, M_ROM | M_ROMOE, 'h05ABC, 0, 1, 0, 0, 0));
        tv.push_back(mk(1, 1, 0, 0, 'hB456, 0, 3, M_RAM | M_RAMOE, 0, 'h01456, 0, 1, 0, 0));

        foreach (tv[i]) begin
            drive(tv[i].rstn, tv[i].cs, tv[i].wr, tv[i].snd, 16'(tv[i].a), 8'(tv[i].d));
            if ((tv[i].mask & M_ROM) != 0)
                chk($sformatf("tv%0d_rom_addr", i), tv[i].dut, 32'(rom_addr_w[tv[i].dut]), tv[i].erom);
            if ((tv[i].mask & M_ROMOE) != 0)
                chk($sformatf("tv%0d_rom_oe", i), tv[i].dut, 32'(rom_oe_w[tv[i].dut]), 32'(tv[i].erom_oe));
            if ((tv[i].mask & M_RAM) != 0)
                chk($sformatf("tv%0d_ram_addr", i), tv[i].dut, 32'(ram_addr_w[tv[i].dut]), tv[i].eram);
            if ((tv[i].mask & M_RAMOE) != 0)
                chk($sformatf("tv%0d_ram_oe", i), tv[i].dut, 32'(ram_oe_w[tv[i].dut]), 32'(tv[i].eram_oe));
            if ((tv[i].mask & M_WE) != 0)
                chk($sformatf("tv%0d_ram_we", i), tv[i].dut, 32'(ram_we_w[tv[i].dut]), 32'(tv[i].ewe));
            if ((tv[i].mask & M_WD) != 0)
                chk($sformatf("tv%0d_ram_wdata", i), tv[i].dut, 32'(ram_wdata_w[tv[i].dut]), tv[i].ewd);
        end

        // Strobe held three clks into enabled RAM: one write pulse only.
        drive(1, 1, 1, 1, 16'hA005, 8'h5A);
        chk("hold_we_first", 0, 32'(ram_we_w[0]), 1);
        chk("hold_ram_addr", 0, 32'(ram_addr_w[0]), 'h00005);
        chk("hold_ram_wdata", 0, 32'(ram_wdata_w[0]), 'h5A);
        drive(1, 1, 1, 1, 16'hA005, 8'h5A);
        chk("hold_we_2nd", 0, 32'(ram_we_w[0]), 0);
        drive(1, 1, 1, 1, 16'hA005, 8'h5A);
        chk("hold_we_3rd", 0, 32'(ram_we_w[0]), 0);
        drive(1, 1, 0, 1, 16'hA005, 8'h5A);
        chk("hold_we_release", 0, 32'(ram_we_w[0]), 0);

        // Disabled RAM swallows writes.
        drive(1, 0, 1, 1, 16'h0000, 8'h00);
        drive(1, 0, 0, 0, 16'h0000, 8'h00);
        chk("dis_ram_enabled", 0, 32'(ram_en_w[0]), 0);
        drive(1, 1, 1, 1, 16'hA007, 8'h33);
        chk("dis_ram_we", 0, 32'(ram_we_w[0]), 0);
        chk("dis_ram_oe", 0, 32'(ram_oe_w[0]), 0);
        drive(1, 1, 0, 0, 16'hA007, 8'h33);

        // Write strobe straddling reset release must not commit.
        drive(1, 0, 1, 1, 16'h2000, 8'h1F);
        drive(1, 0, 0, 0, 16'h0000, 8'h00);
        drive(0, 0, 1, 1, 16'h0000, 8'h0A);
        drive(1, 0, 1, 1, 16'h0000, 8'h0A);
        chk("rst_straddle_ram_en", 0, 32'(ram_en_w[0]), 0);
        drive(1, 0, 0, 1, 16'h4000, 8'h00);
        chk("rst_straddle_rom_addr", 0, 32'(rom_addr_w[0]), 'h04000);
        chk("rst_straddle_rom_addr5", 1, 32'(rom_addr_w[1]), 'h04000);
        chk("rst_straddle_ram_en5", 1, 32'(ram_en_w[1]), 0);

        // Random bus traffic; writes keep address/data stable while the strobe is held.
        rw = 1'b0; ra = '0; rd = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!(rw && $urandom_range(0, 1) == 0)) begin
                case ($urandom_range(0, 5))
                    0:       ra = 16'($urandom_range(0, 'h1FFF));
                    1:       ra = 16'($urandom_range('h2000, 'h3FFF));
                    2:       ra = 16'($urandom_range('h4000, 'h7FFF));
                    3, 4:    ra = 16'($urandom_range('hA000, 'hBFFF));
                    default: ra = 16'($urandom_range(0, 'hFFFF));
                endcase
                rd = ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom);
                rw = $urandom_range(0, 2) == 0;
            end
            rs = $urandom_range(0, 7) != 0;
            rr = $urandom_range(0, 199) != 0;
            drive(rr, ra[15], rw, rs, ra, rd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
